// File: rtl/fx_mac_seq.sv
// Operand sequencer and result collector in front of fx_mac: buffers one weight and one
// data vector, streams them as K back-to-back pairs, and returns the MAC result on a valid/ready port.
module fx_mac_seq #(
  parameter int WIDTH = 8,
  parameter int K     = 2,
  parameter int WK    = $clog2(K),
  parameter int TMO   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_vld,
  input  logic             ld_sel,
  input  logic [WK-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             start,
  output logic             busy,
  output logic             mac_clr,
  output logic             mac_vld,
  output logic [WIDTH-1:0] mac_win,
  output logic [WIDTH-1:0] mac_din,
  input  logic             mac_vld_i,
  input  logic [WIDTH-1:0] mac_acc_i,
  output logic [WIDTH-1:0] res_o,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic             res_err
);

  // Result port: res_o/res_err are held while res_vld=1; a transfer happens on
  // any rising clk edge where res_vld && res_rdy, and res_vld drops the next cycle.

  localparam int WW = $clog2(TMO + 1);
  localparam logic [WK-1:0] IDX_LAST  = WK'(K - 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_STREAM = 3'd2,
    S_WAIT   = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] wbuf [K];
  logic [WIDTH-1:0] dbuf [K];
  logic [WK-1:0]    idx;
  logic [WW-1:0]    wdog;
  logic             seen;
  logic             ld_ok;

  // Widened compare so an out-of-range address is rejected for any K.
  assign ld_ok = ld_vld && (state == S_IDLE) && ({1'b0, ld_addr} < (WK + 1)'(K));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      wdog    <= '0;
      seen    <= 1'b0;
      busy    <= 1'b0;
      mac_clr <= 1'b0;
      mac_vld <= 1'b0;
      mac_win <= '0;
      mac_din <= '0;
      res_o   <= '0;
      res_vld <= 1'b0;
      res_err <= 1'b0;
      for (int i = 0; i < K; i++) begin
        wbuf[i] <= '0;
        dbuf[i] <= '0;
      end
    end else begin
      mac_clr <= 1'b0;
      mac_vld <= 1'b0;

      if (ld_ok) begin
        if (ld_sel) dbuf[ld_addr] <= ld_val;
        else        wbuf[ld_addr] <= ld_val;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_CLR;
            busy    <= 1'b1;
            mac_clr <= 1'b1;
          end
        end

        // Pair 0 leaves in the cycle after the clear so start-to-first-pair is 2 cycles.
        S_CLR: begin
          mac_vld <= 1'b1;
          mac_win <= wbuf[0];
          mac_din <= dbuf[0];
          idx     <= WK'(1);
          state   <= S_STREAM;
        end

        S_STREAM: begin
          mac_vld <= 1'b1;
          mac_win <= wbuf[idx];
          mac_din <= dbuf[idx];
          if (idx == IDX_LAST) begin
            state <= S_WAIT;
            wdog  <= '0;
            seen  <= 1'b0;
          end else begin
            idx <= idx + WK'(1);
          end
        end

        S_WAIT: begin
          if (mac_vld_i) begin
            res_o <= mac_acc_i;
            seen  <= 1'b1;
          end else if (seen) begin
            state   <= S_HOLD;
            res_vld <= 1'b1;
            res_err <= 1'b0;
          end else if (wdog == WDOG_LAST) begin
            state   <= S_HOLD;
            res_vld <= 1'b1;
            res_err <= 1'b1;
            res_o   <= '0;
          end else begin
            wdog <= wdog + WW'(1);
          end
        end

        S_HOLD: begin
          if (res_rdy) begin
            state   <= S_IDLE;
            res_vld <= 1'b0;
            res_err <= 1'b0;
            busy    <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fx_mac_seq.sv
// Directed bench for fx_mac_seq with a behavioural fx_mac stand-in (Q4 round, saturate to 8 bits).
module tb_fx_mac_seq;

  localparam int WIDTH = 8;
  localparam int K     = 2;
  localparam int WK    = 1;
  localparam int TMO   = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             ld_vld;
  logic             ld_sel;
  logic [WK-1:0]    ld_addr;
  logic [WIDTH-1:0] ld_val;
  logic             start;
  logic             busy;
  logic             mac_clr;
  logic             mac_vld;
  logic [WIDTH-1:0] mac_win;
  logic [WIDTH-1:0] mac_din;
  logic             mac_vld_i;
  logic [WIDTH-1:0] mac_acc_i;
  logic [WIDTH-1:0] res_o;
  logic             res_vld;
  logic             res_rdy;
  logic             res_err;

  fx_mac_seq #(.WIDTH(WIDTH), .K(K), .WK(WK), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .ld_vld(ld_vld), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_val(ld_val),
    .start(start), .busy(busy),
    .mac_clr(mac_clr), .mac_vld(mac_vld), .mac_win(mac_win), .mac_din(mac_din),
    .mac_vld_i(mac_vld_i), .mac_acc_i(mac_acc_i),
    .res_o(res_o), .res_vld(res_vld), .res_rdy(res_rdy), .res_err(res_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- fx_mac stand-in ----------------
  bit mac_dead = 1'b0;
  initial begin
    int cnt, cd, outph;
    int acc, r;
    logic [WIDTH-1:0] sat;
    cnt = 0; cd = 0; outph = 0; acc = 0;
    mac_vld_i = 1'b0;
    mac_acc_i = '0;
    forever begin
      @(posedge clk);
      #1;
      mac_vld_i = 1'b0;
      if (rst || mac_clr) begin
        acc = 0; cnt = 0; cd = 0; outph = 0;
      end else begin
        r = (acc + 8) >>> 4;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        sat = WIDTH'(r);
        if (outph > 0) begin
          mac_vld_i = !mac_dead;
          // First beat carries a partial value; only the last beat is the result.
          mac_acc_i = (outph == 2) ? (sat ^ 8'h55) : sat;
          outph--;
        end
        if (cd > 0) begin
          cd--;
          if (cd == 0) outph = 2;
        end
        if (mac_vld) begin
          acc = acc + int'($signed(mac_win)) * int'($signed(mac_din));
          cnt++;
          if (cnt == K) cd = 2;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [15:0] pair_q[$];
  logic [15:0] exp_q[$];
  int clr_cnt, rv_cnt, xfer_cnt, last_vld_cyc, last_mvi_cyc, rv_cyc;

  always @(negedge clk) begin
    if (mac_clr) clr_cnt++;
    if (mac_vld) begin
      pair_q.push_back({mac_win, mac_din});
      last_vld_cyc = cyc;
    end
    if (mac_vld_i) last_mvi_cyc = cyc;
    if (res_vld) begin
      if (rv_cnt == 0) rv_cyc = cyc;
      rv_cnt++;
      if (res_rdy) xfer_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic ld(input logic sel, input logic [WK-1:0] addr, input logic [WIDTH-1:0] val);
    ld_vld = 1'b1; ld_sel = sel; ld_addr = addr; ld_val = val;
    tick();
    ld_vld = 1'b0;
  endtask

  task automatic load4(input logic [7:0] w0, input logic [7:0] w1,
                       input logic [7:0] d0, input logic [7:0] d1);
    ld(1'b0, 1'b0, w0);
    ld(1'b0, 1'b1, w1);
    ld(1'b1, 1'b0, d0);
    ld(1'b1, 1'b1, d1);
  endtask

  // mode: 0 plain, 1 backpressure, 2 load writes during the operation, 3 timeout
  task automatic run_op(input string nm,
                        input logic [7:0] w0, input logic [7:0] w1,
                        input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] exp_res, input logic exp_err, input int mode);
    int n;
    pair_q.delete();
    exp_q.delete();
    exp_q.push_back({w0, d0});
    exp_q.push_back({w1, d1});
    clr_cnt = 0; rv_cnt = 0; xfer_cnt = 0; rv_cyc = 0; last_vld_cyc = 0; last_mvi_cyc = 0;
    res_rdy = (mode != 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    ld_vld = 1'b0;
    n = 0;
    while (!res_vld && n < 200) begin
      if (mode == 2 && n < 6) begin
        ld_vld = 1'b1; ld_sel = n[1]; ld_addr = n[0]; ld_val = 8'h5A;
      end else begin
        ld_vld = 1'b0;
      end
      tick();
      n++;
    end
    ld_vld = 1'b0;
    chk({nm, "_res_vld_seen"}, {31'd0, res_vld}, 32'd1);
    chk({nm, "_res_o"}, {24'd0, res_o}, {24'd0, exp_res});
    chk({nm, "_res_err"}, {31'd0, res_err}, {31'd0, exp_err});
    if (mode == 1) begin
      for (int i = 0; i < 10; i++) begin
        start = i[0];
        tick();
        chk({nm, "_hold_vld"}, {31'd0, res_vld}, 32'd1);
        chk({nm, "_hold_res"}, {24'd0, res_o}, {24'd0, exp_res});
        chk({nm, "_hold_busy"}, {31'd0, busy}, 32'd1);
      end
      start = 1'b0;
      res_rdy = 1'b1;
    end
    tick();
    chk({nm, "_vld_drop"}, {31'd0, res_vld}, 32'd0);
    chk({nm, "_idle"}, {31'd0, busy}, 32'd0);
    tick();
    tick();
    chk({nm, "_stay_idle"}, {31'd0, busy}, 32'd0);
    chk({nm, "_xfer_cnt"}, xfer_cnt, 32'd1);
    if (mode != 1) chk({nm, "_rv_cnt"}, rv_cnt, 32'd1);
    chk({nm, "_clr_cnt"}, clr_cnt, 32'd1);
    chk({nm, "_pair_cnt"}, pair_q.size(), K);
    while (exp_q.size() > 0 && pair_q.size() > 0)
      chk({nm, "_pair"}, {16'd0, pair_q.pop_front()}, {16'd0, exp_q.pop_front()});
    if (mode == 3) chk({nm, "_tmo_cycles"}, rv_cyc - last_vld_cyc, TMO);
    else           chk({nm, "_rv_latency"}, rv_cyc - last_mvi_cyc, 32'd2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst = 1'b1; ld_vld = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_val = '0;
    start = 1'b0; res_rdy = 1'b1;
    tick(); tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mac_clr", {31'd0, mac_clr}, 32'd0);
    chk("rst_mac_vld", {31'd0, mac_vld}, 32'd0);
    chk("rst_mac_pair", {16'd0, mac_win, mac_din}, 32'd0);
    chk("rst_res", {22'd0, res_o, res_vld, res_err}, 32'd0);
    rst = 1'b0;
    tick();

    // 16*32 + 16*24 = 896 -> Q4 0x38
    load4(8'h10, 8'h10, 8'h20, 8'h18);
    run_op("basic", 8'h10, 8'h10, 8'h20, 8'h18, 8'h38, 1'b0, 0);

    load4(8'h7F, 8'h7F, 8'h7F, 8'h7F);
    run_op("sat_pos", 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b0, 0);

    ld(1'b1, 1'b0, 8'h80);
    ld(1'b1, 1'b1, 8'h80);
    run_op("sat_neg", 8'h7F, 8'h7F, 8'h80, 8'h80, 8'h80, 1'b0, 0);

    load4(8'h10, 8'h10, 8'h20, 8'h18);
    run_op("bkpr", 8'h10, 8'h10, 8'h20, 8'h18, 8'h38, 1'b0, 1);

    run_op("guard", 8'h10, 8'h10, 8'h20, 8'h18, 8'h38, 1'b0, 2);
    run_op("after_guard", 8'h10, 8'h10, 8'h20, 8'h18, 8'h38, 1'b0, 0);

    // Write w[1]=0x20 in the start cycle: 16*32 + 32*24 = 1280 -> 0x50
    ld_vld = 1'b1; ld_sel = 1'b0; ld_addr = 1'b1; ld_val = 8'h20;
    run_op("ld_start", 8'h10, 8'h20, 8'h20, 8'h18, 8'h50, 1'b0, 0);

    mac_dead = 1'b1;
    run_op("timeout", 8'h10, 8'h20, 8'h20, 8'h18, 8'h00, 1'b1, 3);
    mac_dead = 1'b0;

    // Reset while pairs are streaming.
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!mac_vld && n < 20) begin
      tick();
      n++;
    end
    chk("midrst_in_stream", {31'd0, mac_vld}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_mac_vld", {31'd0, mac_vld}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_res_vld", {31'd0, res_vld}, 32'd0);
    tick();
    run_op("post_rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=finished", cyc);
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/fx_mac_seq.md
Name: fx_mac_seq

Overview:
- Operand sequencer and result collector that sits directly upstream of fx_mac. It feeds fx_mac and consumes what fx_mac produces.
- Holds one K-element weight vector and one K-element data vector, loaded through a simple write port.
- On start it clears the MAC, streams the K operand pairs back-to-back, then captures the clipped and rounded MAC output.
- It presents the result on a valid/ready port and supervises the MAC with a watchdog.

Parameters:
- WIDTH, 8, operand/result bit width (signed, Q-format identical to fx_mac).
- K, 2, operand pairs per dot product; must be ≥2 and match fx_mac K.
- WK, $clog2(K), buffer address width.
- TMO, 16, max cycles in WAIT before a timeout is declared (≥8).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ld_vld  in  1  write strobe for operand buffers
- ld_sel  in  1  0 = weight buffer, 1 = data buffer
- ld_addr  in  WK  buffer index
- ld_val  in  WIDTH  signed operand value
- start  in  1  begin one dot product
- busy  out  1  high in any state except IDLE
- mac_clr  out  1  one-cycle clear to fx_mac (integration inverts it onto rstn)
- mac_vld  out  1  drives fx_mac vld_i
- mac_win  out  WIDTH  drives fx_mac win
- mac_din  out  WIDTH  drives fx_mac din
- mac_vld_i  in  1  fx_mac vld_o
- mac_acc_i  in  WIDTH  fx_mac acc_o
- res_o  out  WIDTH  captured result
- res_vld  out  1  result valid
- res_rdy  in  1  consumer ready
- res_err  out  1  qualifies res_o as a timeout result (res_o = 0)

Behaviour:
- Reset: all outputs and registers go to 0, both buffers are cleared to 0, FSM enters IDLE. Reset in any state aborts the operation with no result.
- All outputs are registered.
- Loads:
  - ld_vld writes ld_val into the buffer selected by ld_sel at ld_addr, in IDLE only; writes in other states are ignored.
  - ld_addr ≥ K is ignored.
  - ld_vld and start in the same cycle: the write happens and start is accepted, so the new value is used.
- State IDLE: start=1 → CLR. start in any other state is ignored.
- State CLR: mac_clr=1 for exactly one cycle; element index idx is set to 0; → STREAM.
- State STREAM:
  - For K consecutive cycles: mac_vld=1, mac_win=wbuf[idx], mac_din=dbuf[idx], idx = 0..K-1 in order, no bubbles.
  - After the K-th pair, mac_vld returns to 0, the watchdog is cleared, → WAIT.
- State WAIT:
  - Each cycle mac_vld_i=1, res_o is loaded with mac_acc_i.
  - On the first cycle mac_vld_i=0 after at least one high cycle, → HOLD with res_err=0. The last captured value (final acc_o) is the result.
  - Watchdog counts WAIT cycles; if it reaches TMO without mac_vld_i having risen → HOLD with res_o=0 and res_err=1.
- State HOLD:
  - res_vld=1; res_o and res_err are stable.
  - res_vld && res_rdy → IDLE the next cycle, with res_vld=0.
  - res_rdy may be high early; the transfer occurs on the first cycle res_vld is high.
- Latency:
  - start to first mac_vld = 2 cycles.
  - fx_mac asserts vld_o 2 cycles after the last pair plus its pipeline; res_vld rises the cycle after mac_vld_i falls.
- Arithmetic: no arithmetic in this block. Values are passed bit-exact; signedness is preserved.
- Back-to-back: a new start is accepted in the IDLE cycle after the handshake. Buffers retain their contents across operations.

Test Plan:
- Basic dot product (WIDTH=8, FRACTION=4, K=2):
  - Stimulus: load w={0x10,0x10}, d={0x20,0x18}, start, res_rdy=1, real fx_mac attached.
  - Required: mac_clr one cycle; mac_vld exactly 2 cycles with pairs (0x10,0x20), (0x10,0x18); res_o=0x38, res_err=0, res_vld one cycle.
- Saturation:
  - Stimulus: w={0x7F,0x7F}, d={0x7F,0x7F}.
  - Required: res_o=0x7F. With d={0x80,0x80}: res_o=0x80.
- Backpressure:
  - Stimulus: res_rdy=0 for 10 cycles after res_vld.
  - Required: res_vld, res_o and busy held; start pulses during HOLD are ignored; one transfer occurs when res_rdy=1.
- Load guards:
  - Stimulus: ld_vld during STREAM with new values, then ld_addr=K in IDLE.
  - Required: the in-flight operands are unchanged, buffers are unchanged, and the next result matches the old vectors.
- Timeout:
  - Stimulus: stub MAC with mac_vld_i tied 0.
  - Required: HOLD after exactly TMO WAIT cycles; res_err=1, res_o=0.
- Reset mid-op:
  - Stimulus: rst=1 for one cycle during STREAM.
  - Required: next cycle mac_vld=0, busy=0, res_vld=0, buffers read 0; a subsequent start produces res_o=0.
